// File: rtl/alu_ext_pipe_pkg.sv
// Purpose: shared encodings for the pipelined execute-stage ALU/shifter.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: opcode enum, B-operand select enum, shift kind, FSM states, width helpers.
package alu_ext_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned IMM_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'd0,
        OP_PADDSB = 4'd1,
        OP_SUB    = 4'd2,
        OP_NAND   = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_LLB    = 4'd8,
        OP_LHB    = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        BSEL_REG      = 2'd0,
        BSEL_IMM4     = 2'd1,
        BSEL_IMM8     = 2'd2,
        BSEL_IMM8_ALT = 2'd3
    } bsel_e;

    typedef enum logic [1:0] {
        SHK_LL = 2'd0,
        SHK_RL = 2'd1,
        SHK_RA = 2'd2
    } shk_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to encode a shift distance of 0..width-1.
    function automatic int unsigned shamt_bits(input int unsigned width);
        return $clog2(width);
    endfunction

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_SHAMT_W = shamt_bits(DEF_WIDTH);

endpackage

// File: rtl/alu_ext_pipe_if.sv
// Purpose: operation/result bundle between operand fetch, the ALU and writeback.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: slave = ALU view, master = requester/consumer view.
interface alu_ext_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [7:0]       imm;
    logic [1:0]       b_sel;
    logic [2:0]       flag_we;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;

    modport slave (
        input  in_valid, op, src_a, src_b, imm, b_sel, flag_we, out_ready,
        output in_ready, out_valid, result, flag_n, flag_v, flag_z
    );

    modport master (
        output in_valid, op, src_a, src_b, imm, b_sel, flag_we, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_v, flag_z
    );
endinterface

// File: rtl/alu_ext_pipe_lane_sat_add.sv
// Purpose: signed LANE-bit adder that clamps to +max/-min on overflow.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i lane operands; sum_o clamped sum; sat_o set when clamping occurred.
module lane_sat_add #(
    parameter int unsigned LANE = 4
) (
    input  logic [LANE-1:0] a_i,
    input  logic [LANE-1:0] b_i,
    output logic [LANE-1:0] sum_o,
    output logic            sat_o
);
    logic [LANE:0] full_sum;

    assign full_sum = {a_i[LANE-1], a_i} + {b_i[LANE-1], b_i};

    // The two top bits of the sign-extended sum disagree exactly on overflow;
    // the extra top bit carries the true sign and picks the clamp direction.
    assign sat_o = full_sum[LANE] ^ full_sum[LANE-1];

    always_comb begin
        sum_o = full_sum[LANE-1:0];
        if (sat_o) begin
            sum_o = full_sum[LANE] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
        end
    end
endmodule

// File: rtl/alu_ext_pipe.sv
// Purpose: execute-stage ALU with packed saturating add, iterative shifter and N/V/Z flags.
// Latency: 1 cycle for ALU ops; max(1, ceil(s/SHF_STEP)) cycles for shifts.
// Backpressure: accepts only in IDLE while the result register is free or draining.
// Ports: clk, rst_n (sync, active low); bus = alu_ext_pipe_if.slave (request, result, flags).
module alu_ext_pipe
    import alu_ext_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LANE     = 4,
    parameter int unsigned SHF_STEP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_ext_pipe_if.slave  bus
);
    localparam int unsigned SAW = shamt_bits(WIDTH);
    localparam int unsigned NL  = WIDTH / LANE;
    localparam logic [SAW-1:0] STEP_C = SAW'(SHF_STEP);

    // ---------------- state ----------------
    state_e           state_q,     state_d;
    logic [WIDTH-1:0] sh_val_q,    sh_val_d;
    logic [SAW-1:0]   rem_q,       rem_d;
    shk_e             sh_kind_q,   sh_kind_d;
    logic [2:0]       sh_we_q,     sh_we_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             flag_n_q,    flag_n_d;
    logic             flag_v_q,    flag_v_d;
    logic             flag_z_q,    flag_z_d;

    // ---------------- handshake ----------------
    logic load_ok;
    logic in_rdy;
    logic accept;

    assign load_ok = !out_valid_q || bus.out_ready;
    assign in_rdy  = (state_q == ST_IDLE) && load_ok;
    assign accept  = bus.in_valid && in_rdy;

    // ---------------- operand B ----------------
    logic [WIDTH-1:0] b_val;

    always_comb begin
        case (bus.b_sel)
            BSEL_REG:  b_val = bus.src_b;
            BSEL_IMM4: b_val = {{(WIDTH-4){bus.imm[3]}}, bus.imm[3:0]};
            default:   b_val = {{(WIDTH-8){bus.imm[7]}}, bus.imm};
        endcase
    end

    // ---------------- packed saturating add ----------------
    logic [WIDTH-1:0] padd_res;
    logic [NL-1:0]    lane_sat;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        lane_sat_add #(.LANE(LANE)) u_lane (
            .a_i   (bus.src_a[g*LANE +: LANE]),
            .b_i   (b_val[g*LANE +: LANE]),
            .sum_o (padd_res[g*LANE +: LANE]),
            .sat_o (lane_sat[g])
        );
    end

    // ---------------- shifter step ----------------
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic [SAW-1:0]   amt,
        input shk_e             kind
    );
        case (kind)
            SHK_LL:  return v << amt;
            SHK_RL:  return v >> amt;
            default: return $unsigned($signed(v) >>> amt);
        endcase
    endfunction

    function automatic logic [SAW-1:0] clip_step(input logic [SAW-1:0] x);
        return (x > STEP_C) ? STEP_C : x;
    endfunction

    // ---------------- ALU ----------------
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             is_shift;
    shk_e             kind;
    logic [WIDTH-1:0] sum_res;
    logic [WIDTH-1:0] diff_res;

    assign sum_res  = bus.src_a + b_val;
    assign diff_res = bus.src_a - b_val;

    always_comb begin
        alu_res  = bus.src_a ^ b_val;
        alu_v    = 1'b0;
        is_shift = 1'b0;
        kind     = SHK_LL;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum_res;
                alu_v   = (bus.src_a[WIDTH-1] == b_val[WIDTH-1]) &&
                          (sum_res[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_res;
                alu_v   = (bus.src_a[WIDTH-1] != b_val[WIDTH-1]) &&
                          (diff_res[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            OP_PADDSB: begin
                alu_res = padd_res;
                alu_v   = |lane_sat;
            end
            OP_NAND: alu_res = ~(bus.src_a & b_val);
            OP_SLL: begin is_shift = 1'b1; kind = SHK_LL; end
            OP_SRL: begin is_shift = 1'b1; kind = SHK_RL; end
            OP_SRA: begin is_shift = 1'b1; kind = SHK_RA; end
            OP_LLB: alu_res = {{(WIDTH-8){bus.imm[7]}}, bus.imm};
            OP_LHB: alu_res = {bus.imm, bus.src_a[WIDTH-9:0]};
            default: alu_res = bus.src_a ^ b_val;
        endcase
    end

    // First slice of a shift is applied on the accept edge itself.
    logic [SAW-1:0]   shamt;
    logic [SAW-1:0]   first_amt;
    logic [SAW-1:0]   first_rem;
    logic [WIDTH-1:0] first_val;
    logic [SAW-1:0]   cont_amt;
    logic [SAW-1:0]   cont_rem;
    logic [WIDTH-1:0] cont_val;

    assign shamt     = bus.imm[SAW-1:0];
    assign first_amt = clip_step(shamt);
    assign first_rem = shamt - first_amt;
    assign first_val = shift_step(bus.src_a, first_amt, kind);
    // With rem_q == 0 (waiting on a busy result register) this is a no-op step.
    assign cont_amt  = clip_step(rem_q);
    assign cont_rem  = rem_q - cont_amt;
    assign cont_val  = shift_step(sh_val_q, cont_amt, sh_kind_q);

    // ---------------- next state ----------------
    logic             do_load;
    logic [WIDTH-1:0] load_val;
    logic             load_v;
    logic [2:0]       load_we;

    always_comb begin
        state_d     = state_q;
        sh_val_d    = sh_val_q;
        rem_d       = rem_q;
        sh_kind_d   = sh_kind_q;
        sh_we_d     = sh_we_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_n_d    = flag_n_q;
        flag_v_d    = flag_v_q;
        flag_z_d    = flag_z_q;
        do_load     = 1'b0;
        load_val    = '0;
        load_v      = 1'b0;
        load_we     = 3'b000;

        // Consumer took the held result; re-asserted below if a new one lands.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_SHIFT: begin
                if (cont_rem == '0 && load_ok) begin
                    do_load  = 1'b1;
                    load_val = cont_val;
                    load_we  = sh_we_q;
                    state_d  = ST_IDLE;
                    rem_d    = '0;
                end else begin
                    // Finished shifts park here with rem=0 until the result register frees.
                    sh_val_d = cont_val;
                    rem_d    = cont_rem;
                end
            end
            default: begin
                if (accept) begin
                    if (is_shift && first_rem != '0) begin
                        state_d   = ST_SHIFT;
                        sh_val_d  = first_val;
                        rem_d     = first_rem;
                        sh_kind_d = kind;
                        sh_we_d   = bus.flag_we;
                    end else begin
                        do_load  = 1'b1;
                        load_val = is_shift ? first_val : alu_res;
                        load_v   = is_shift ? 1'b0 : alu_v;
                        load_we  = bus.flag_we;
                    end
                end
            end
        endcase

        if (do_load) begin
            result_d    = load_val;
            out_valid_d = 1'b1;
            if (load_we[2]) flag_n_d = load_val[WIDTH-1];
            if (load_we[1]) flag_v_d = load_v;
            if (load_we[0]) flag_z_d = (load_val == '0);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sh_val_q    <= '0;
            rem_q       <= '0;
            sh_kind_q   <= SHK_LL;
            sh_we_q     <= 3'b000;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_val_q    <= sh_val_d;
            rem_q       <= rem_d;
            sh_kind_q   <= sh_kind_d;
            sh_we_q     <= sh_we_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
            flag_z_q    <= flag_z_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_v    = flag_v_q;
    assign bus.flag_z    = flag_z_q;

endmodule

// File: doc/alu_ext_pipe.md
Name: alu_ext_pipe

Overview:
Parametrised, pipelined successor of the 16-bit execute-stage ALU/shifter. It accepts one operation per cycle over a valid/ready handshake and registers the result. It also holds the architectural N/V/Z flag register, updated by a per-operation write mask. Shifts run iteratively at SHF_STEP bits per cycle so that wide datapaths avoid a full barrel shifter. Sits between decode/operand-fetch and the memory/writeback stage.

Parameters:
WIDTH, 16, datapath width; multiple of LANE, >= 16
LANE, 4, lane width for the saturating packed add (PADDSB); divides WIDTH
SHF_STEP, 4, maximum shift distance applied per cycle; 1..WIDTH-1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid && in_ready
op  in  4  0 ADD, 1 PADDSB, 2 SUB, 3 NAND, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LLB, 9 LHB; others are treated as XOR
src_a  in  WIDTH  operand A; shift source; LHB low-part source
src_b  in  WIDTH  register operand B
imm  in  8  instruction immediate
b_sel  in  2  B select: 0 src_b, 1 sign-extended imm[3:0], 2/3 sign-extended imm[7:0]
flag_we  in  3  flag update mask {N,V,Z}, latched at accept
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer takes the result when out_valid && out_ready
result  out  WIDTH  registered result
flag_n, flag_v, flag_z  out  1 each  architectural flag register

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, result=0, flags=0, FSM=IDLE, shift counter=0. Reset takes priority over every other event, including an in-flight shift, which is discarded.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready.
  - SHIFT: in_ready=0.
- ALU ops and LLB/LHB: an op accepted at edge t gives out_valid=1 with the result from edge t+1. Throughput is 1 per cycle when out_ready=1.
- ADD/SUB: modulo 2^WIDTH. V = signed overflow.
- PADDSB: per LANE-bit signed lane, A+B saturates to +max/-min. V = OR of the lane saturation flags.
- NAND, XOR: bitwise; V=0.
- LLB: result = sign-extended imm; V=0.
- LHB: result = {imm, src_a[WIDTH-9:0]}; V=0.
- All ops: N = result[WIDTH-1]; Z = (result==0).
- Shifts:
  - Amount s = imm[$clog2(WIDTH)-1:0]; B is ignored.
  - SLL/SRL are logical shifts; SRA replicates the MSB.
  - The first min(s,SHF_STEP) bits are applied at the accept edge.
  - If bits remain, the FSM enters SHIFT and applies min(rem,SHF_STEP) bits per cycle.
  - out_valid rises at edge t+max(1,ceil(s/SHF_STEP)). s=0 behaves like a 1-cycle op.
  - V=0.
- Result register:
  - It loads only when the op completes and (!out_valid || out_ready). Otherwise result and out_valid hold stable (no overwrite under back-pressure).
  - When out_ready=1 and no completion occurs in the cycle, out_valid drops to 0.
- Shift completion under back-pressure: if a shift finishes while out_valid && !out_ready, the FSM stays in SHIFT with rem=0 until the register frees.
- Flags: on the edge that loads the result register, each flag whose flag_we bit is set takes the new value; unmasked flags hold. Flags are not touched on any other edge.
- Simultaneous drain and accept in IDLE: the old result is consumed and the new op is accepted on the same edge.

Decomposition:
- Package alu_ext_pkg: op encoding constants, b_sel encodings, and a localparam for the shift-amount width.
- Sub-module lane_sat_add (a parametric LANE-wide saturating adder with an overflow flag), instantiated WIDTH/LANE times.
- The iterative shifter and FSM live in the top module.

Test Plan:
1. WIDTH=16. ADD src_a=0x7FFF, src_b=0x0001, b_sel=0, flag_we=111 -> at t+1: result=0x8000, N=1, V=1, Z=0.
2. PADDSB src_a=0x7801, src_b=0x1F11 (LANE=4) -> result=0x7812, V=1.
3. SRA src_a=0x8000, imm=9, SHF_STEP=4, out_ready=1 -> in_ready=0 at t+1..t+2; out_valid at t+3 with result=0xFFC0; SLL with imm=0 completes at t+1 with result unchanged.
4. out_ready=0: issue two ADDs back-to-back -> first result held stable, in_ready=0 while out_valid=1 and the second op stays offered. Raise out_ready -> drain and accept occur on the same edge, and the second result appears at the next edge.
5. XOR src_a=src_b=0x1234, flag_we=000 after flags N=1 V=1 Z=0 -> result=0x0000, flags unchanged. Then LLB imm=0x80 with flag_we=001 -> result=0xFF80, Z=0, N/V unchanged. Then LHB src_a=0x00CD, imm=0xAB -> result=0xABCD.
6. rst_n=0 for one edge during the SHIFT state of an SLL with imm=15 -> next cycle out_valid=0, flags=0, in_ready=1, and no stale result ever appears.
